// File: rtl/and_gate_selftest_ctrl_pkg.sv
// Shared definitions for the AND-gate self-test sequencer: state encodings,
// vector order and the reference AND function.
package and_gate_selftest_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Vectors are walked as {a,b} = 00, 01, 10, 11
    localparam logic [1:0] VEC_FIRST = 2'b00;
    localparam logic [1:0] VEC_LAST  = 2'b11;

    localparam int CNT_W = 4;

    function automatic logic expected_and(input logic [1:0] vec);
        return vec[1] & vec[0];
    endfunction

endpackage

// File: rtl/and_gate_selftest_ctrl_settle_timer.sv
// Loadable down-counter that marks the last cycle of the settle window.
module and_gate_selftest_ctrl_settle_timer
    import and_gate_selftest_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Terminal count is 1 so the settle state lasts exactly the loaded value
    assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/and_gate_selftest_ctrl.sv
// Hardware self-test sequencer: sweeps a two-input AND gate through all
// input vectors, checks its output and reports fail/error count.
module and_gate_selftest_ctrl
    import and_gate_selftest_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int PASSES     = 2,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             and_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec
);

    // state    | meaning
    // IDLE     | waiting for start, gate inputs held low
    // DRIVE    | register the next vector onto a_o/b_o, load settle timer
    // SETTLE   | wait SETTLE_CYC cycles for the gate output to settle
    // CHECK    | compare and_i against the expected AND, advance vector/pass
    // DONE     | one-cycle done pulse, then back to IDLE

    localparam logic [CNT_W-1:0] SETTLE_V  = CNT_W'(SETTLE_CYC);
    localparam logic [3:0]       PASS_LAST = 4'(PASSES - 1);

    state_t     state;
    logic [1:0] vec;
    logic [3:0] pass_cnt;
    logic       timer_load;
    logic       timer_expired;
    logic       mismatch;

    assign timer_load = (state == ST_DRIVE);
    assign mismatch   = (and_i != expected_and({a_o, b_o}));

    and_gate_selftest_ctrl_settle_timer u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .value   (SETTLE_V),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            vec            <= VEC_FIRST;
            pass_cnt       <= '0;
            a_o            <= 1'b0;
            b_o            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vec <= 2'b00;
        end else begin
            done <= 1'b0;
            // Abort outranks every state action, including the CHECK update
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
                a_o   <= 1'b0;
                b_o   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            fail           <= 1'b0;
                            err_cnt        <= '0;
                            first_fail_vec <= 2'b00;
                            vec            <= VEC_FIRST;
                            pass_cnt       <= '0;
                            busy           <= 1'b1;
                            state          <= ST_DRIVE;
                        end
                    end
                    ST_DRIVE: begin
                        a_o   <= vec[1];
                        b_o   <= vec[0];
                        state <= (SETTLE_V == '0) ? ST_CHECK : ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (timer_expired) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (mismatch) begin
                            fail <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (!fail) begin
                                first_fail_vec <= {a_o, b_o};
                            end
                        end
                        if (vec == VEC_LAST && pass_cnt == PASS_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            a_o   <= 1'b0;
                            b_o   <= 1'b0;
                        end else begin
                            vec <= vec + 2'd1;
                            if (vec == VEC_LAST) begin
                                pass_cnt <= pass_cnt + 4'd1;
                            end
                            state <= ST_DRIVE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        a_o   <= 1'b0;
                        b_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_and_gate_selftest_ctrl.sv
// Directed bench for and_gate_selftest_ctrl with a modelled gate that can be
// good, stuck-at-1 or stuck-at-0.
module tb_and_gate_selftest_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, abort0, and_i0;
    logic       a0, b0, busy0, done0, fail0;
    logic [3:0] err0;
    logic [1:0] ffv0;
    int         mode0;

    logic       start1, abort1, and_i1;
    logic       a1, b1, busy1, done1, fail1;
    logic [1:0] err1;
    logic [1:0] ffv1;

    int n_cmp = 0;
    int n_mis = 0;

    // Gate model: 0 = good, 1 = stuck-at-1, 2 = stuck-at-0
    always_comb begin
        and_i0 = 1'b0;
        if (mode0 == 0)      and_i0 = a0 & b0;
        else if (mode0 == 1) and_i0 = 1'b1;
    end
    assign and_i1 = 1'b1;

    and_gate_selftest_ctrl #(.SETTLE_CYC(2), .PASSES(2), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .and_i(and_i0),
        .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .fail(fail0),
        .err_cnt(err0), .first_fail_vec(ffv0)
    );

    and_gate_selftest_ctrl #(.SETTLE_CYC(2), .PASSES(4), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .and_i(and_i1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .fail(fail1),
        .err_cnt(err1), .first_fail_vec(ffv1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
        end
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    // Full default run; checks {a,b,busy,done} after every edge, then results
    task automatic run_full(input int mode, input logic [3:0] exp_err,
                            input logic exp_fail, input logic [1:0] exp_ffv);
        logic [3:0] exp_sig;
        int j;
        mode0 = mode;
        pulse_start0();
        check("edge0", {a0, b0, busy0, done0}, 4'b0010);
        for (int e = 1; e <= 33; e++) begin
            @(posedge clk);
            #1;
            j = ((e - 1) / 4) % 4;
            if (e <= 31)      exp_sig = {j[1], j[0], 1'b1, 1'b0};
            else if (e == 32) exp_sig = 4'b0011;
            else              exp_sig = 4'b0000;
            check($sformatf("m%0d_edge%0d", mode, e), {a0, b0, busy0, done0}, exp_sig);
        end
        check($sformatf("m%0d_err", mode), err0, exp_err);
        check($sformatf("m%0d_fail", mode), fail0, exp_fail);
        check($sformatf("m%0d_ffv", mode), ffv0, exp_ffv);
    endtask

    initial begin
        int done_cnt;
        int done_edge;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; mode0 = 0;
        start1 = 1'b0; abort1 = 1'b0;
        #2;
        check("reset_outs0", {a0, b0, busy0, done0, fail0, err0, ffv0}, 11'd0);
        check("reset_outs1", {a1, b1, busy1, done1, fail1, err1, ffv1}, 9'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_full(0, 4'd0, 1'b0, 2'b00);
        run_full(1, 4'd6, 1'b1, 2'b00);
        run_full(2, 4'd2, 1'b1, 2'b11);

        // Abort during SETTLE of vector 10, with an ignored mid-run start
        mode0 = 1;
        pulse_start0();
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            start0 = (e == 4);
            abort0 = (e == 9);
            if (e == 6)  check("midrun_start_ignored", {a0, b0, busy0}, 3'b011);
            if (e == 9)  check("settle_vec10", {a0, b0, busy0}, 3'b101);
            if (e == 10) check("abort_idle", {a0, b0, busy0, done0}, 4'b0000);
        end
        abort0 = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_err", err0, 4'd2);
        check("abort_fail", fail0, 1'b1);
        check("abort_ffv", ffv0, 2'b00);

        // start and abort together in IDLE: abort wins, results untouched
        @(negedge clk);
        start0 = 1'b1; abort0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0; abort0 = 1'b0;
        @(posedge clk);
        #1;
        check("start_abort_idle", busy0, 1'b0);
        check("start_abort_err", err0, 4'd2);

        // Async reset mid-CHECK of vector 01
        mode0 = 1;
        pulse_start0();
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_state", {a0, b0, busy0, fail0, err0}, 8'b0111_0001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {a0, b0, busy0, done0, fail0, err0, ffv0}, 11'd0);
        @(negedge clk);
        rst = 1'b0;
        run_full(0, 4'd0, 1'b0, 2'b00);

        // Saturation: ERR_W=2, PASSES=4, stuck-at-1 gives 12 mismatches
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        done_edge = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                done_edge = k;
                break;
            end
        end
        check("sat_done_edge", done_edge, 64);
        check("sat_err", err1, 2'd3);
        check("sat_fail", fail1, 1'b1);
        check("sat_ffv", ffv1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
